la_iocfg_ctrl: RTL and testbench

// Sequencer that loads per-pad configuration words into the IO ring's

---
 rtl/la_iocfg_ctrl.sv | 94 +++++++++
 tb/tb_la_iocfg_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/la_iocfg_ctrl.sv
`timescale 1ns/1ps
// la_iocfg_ctrl: loads per-pad config words into the IO ring serial chain, then strobes a capture
module la_iocfg_ctrl #(
   parameter int NPADS = 16,
   parameter int CFGW  = 13,
   parameter int DIVW  = 4,
   parameter int IW    = (NPADS > 1) ? $clog2(NPADS) : 1
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            start,
   input  logic            abort,
   input  logic [DIVW-1:0] div,
   output logic [IW-1:0]   cfg_idx,
   input  logic [CFGW-1:0] cfg_data,
   output logic            busy,
   output logic            done,
   output logic            aborted,
   output logic            ser_clk,
   output logic            ser_data,
   output logic            ser_load
);
   localparam int BW = (CFGW > 1) ? $clog2(CFGW) : 1;
   typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
   state_t state, nxt;
   logic [DIVW-1:0] dv, cnt;
   logic [CFGW-1:0] shreg, shreg_nxt;
   logic [BW-1:0] bitcnt, bitcnt_nxt;
   logic [IW-1:0] idx_nxt;
   logic phase_end;
   // next-state, shift register, bit and pad index sequencing; abort overrides everything
   always_comb begin
      phase_end = (cnt == dv);
      nxt = state;
      shreg_nxt = shreg;
      bitcnt_nxt = bitcnt;
      idx_nxt = cfg_idx;
      case (state)
         IDLE: if (start) begin
            nxt = FETCH;
            idx_nxt = IW'(NPADS - 1);
         end
         FETCH: begin
            shreg_nxt = cfg_data;
            bitcnt_nxt = BW'(CFGW - 1);
            nxt = SHIFT_LO;
         end
         SHIFT_LO: if (phase_end) nxt = SHIFT_HI;
         SHIFT_HI: if (phase_end) begin
            shreg_nxt = shreg << 1;
            if (bitcnt != '0) begin
               bitcnt_nxt = bitcnt - 1'b1;
               nxt = SHIFT_LO;
            end else if (cfg_idx != '0) begin
               idx_nxt = cfg_idx - 1'b1;
               nxt = FETCH;
            end else nxt = LATCH;
         end
         LATCH: if (phase_end) nxt = DONE;
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end
   // state and datapath registers; outputs are decoded from the next state so they are glitch-free and aligned with it
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
         dv <= '0;
         cnt <= '0;
         shreg <= '0;
         bitcnt <= '0;
         cfg_idx <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         aborted <= 1'b0;
         ser_clk <= 1'b0;
         ser_data <= 1'b0;
         ser_load <= 1'b0;
      end else begin
         state <= nxt;
         shreg <= shreg_nxt;
         bitcnt <= bitcnt_nxt;
         cfg_idx <= idx_nxt;
         cnt <= (nxt != state) ? '0 : cnt + 1'b1;
         if (state == IDLE && start) dv <= div;
         busy <= nxt == FETCH || nxt == SHIFT_LO || nxt == SHIFT_HI || nxt == LATCH;
         done <= nxt == DONE;
         aborted <= abort && state != IDLE;
         ser_clk <= nxt == SHIFT_HI;
         ser_data <= (nxt == SHIFT_LO || nxt == SHIFT_HI) ? shreg_nxt[CFGW-1] : 1'b0;
         ser_load <= nxt == LATCH;
      end
   end
endmodule

// File: tb/tb_la_iocfg_ctrl.sv
`timescale 1ns/1ps
// tb_la_iocfg_ctrl: scoreboard bench for the IO ring config sequencer
module tb_la_iocfg_ctrl;
   logic clk = 0, nreset = 0, start = 0, abort = 0;
   logic [3:0] div = 0;
   logic [0:0] cfg_idx;
   logic [2:0] cfg_data;
   logic busy, done, aborted, ser_clk, ser_data, ser_load;
   logic e_start = 0, e_abort = 0;
   logic [1:0] e_div = 0;
   logic [0:0] e_idx;
   logic [0:0] e_data = 1'b1;
   logic e_busy, e_done, e_aborted, e_clk, e_sdata, e_load;
   logic [2:0] words [2];
   logic q [$];
   int tests = 0, fails = 0;

   la_iocfg_ctrl #(.NPADS(2), .CFGW(3), .DIVW(4)) dut (
      .clk(clk), .nreset(nreset), .start(start), .abort(abort), .div(div),
      .cfg_idx(cfg_idx), .cfg_data(cfg_data), .busy(busy), .done(done),
      .aborted(aborted), .ser_clk(ser_clk), .ser_data(ser_data), .ser_load(ser_load));

   la_iocfg_ctrl #(.NPADS(1), .CFGW(1), .DIVW(2)) edut (
      .clk(clk), .nreset(nreset), .start(e_start), .abort(e_abort), .div(e_div),
      .cfg_idx(e_idx), .cfg_data(e_data), .busy(e_busy), .done(e_done),
      .aborted(e_aborted), .ser_clk(e_clk), .ser_data(e_sdata), .ser_load(e_load));

   always #5 clk = ~clk;
   always_comb cfg_data = words[cfg_idx];

   task automatic run_main(input int d, input int abort_hi, input bit spam);
      int exp_done, edges, hi_run;
      logic pclk, exp_bit;
      bit ab_pending;
      exp_done = 2 * (1 + 6 * (d + 1)) + (d + 1) + 1;
      edges = 0; hi_run = 0; pclk = 0; ab_pending = 0;
      q.delete();
      for (int p = 1; p >= 0; p--)
         for (int b = 2; b >= 0; b--) q.push_back(words[p][b]);
      @(negedge clk);
      div = 4'(d);
      start = 1;
      for (int n = 1; n <= exp_done + 3; n++) begin
         @(negedge clk);
         start = spam && ((n < exp_done && n % 3 == 0) || n == exp_done);
         if (ab_pending) begin
            tests++;
            if ({aborted, busy, ser_clk, ser_load} !== 4'b1000) begin
               fails++;
               $display("FAIL abort_response: {aborted,busy,ser_clk,ser_load}=%b exp 1000", {aborted, busy, ser_clk, ser_load});
            end
            abort = 0;
            break;
         end
         tests++;
         if (abort_hi == 0) begin
            if ({busy, done, ser_load} !== {n < exp_done, n == exp_done, n >= exp_done - 1 - d && n <= exp_done - 1}) begin
               fails++;
               $display("FAIL timing d=%0d cycle %0d: {busy,done,load}=%b exp %b", d, n, {busy, done, ser_load},
                        {n < exp_done, n == exp_done, n >= exp_done - 1 - d && n <= exp_done - 1});
            end
         end else if ({done, ser_load} !== 2'b00) begin
            fails++;
            $display("FAIL abort_no_done cycle %0d: {done,load}=%b exp 00", n, {done, ser_load});
         end
         if (ser_clk && !pclk) begin
            edges++;
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL extra_ser_edge %0d: got data %b exp no edge", edges, ser_data);
            end else begin
               exp_bit = q.pop_front();
               if (ser_data !== exp_bit) begin
                  fails++;
                  $display("FAIL ser_data edge %0d: got %b exp %b", edges, ser_data, exp_bit);
               end
            end
            if (abort_hi != 0 && edges == abort_hi) begin
               abort = 1;
               ab_pending = 1;
            end
         end
         if (ser_clk) hi_run++;
         else if (pclk) begin
            tests++;
            if (hi_run != d + 1) begin
               fails++;
               $display("FAIL hi_phase d=%0d: got %0d cycles exp %0d", d, hi_run, d + 1);
            end
            hi_run = 0;
         end
         pclk = ser_clk;
      end
      start = 0;
      abort = 0;
      if (abort_hi == 0) begin
         tests++;
         if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_edges d=%0d: got %0d left exp 0", d, q.size());
         end
      end
      q.delete();
   endtask

   task automatic test_reset;
      #1;
      tests++;
      if ({busy, done, aborted, ser_clk, ser_data, ser_load, cfg_idx} !== 7'b0) begin
         fails++;
         $display("FAIL reset_values: got %b exp 0", {busy, done, aborted, ser_clk, ser_data, ser_load, cfg_idx});
      end
      repeat (2) @(negedge clk);
      nreset = 1;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy, done, ser_clk, ser_load, e_busy} !== 5'b0) begin
         fails++;
         $display("FAIL idle_after_reset: got %b exp 0", {busy, done, ser_clk, ser_load, e_busy});
      end
   endtask

   task automatic test_start_abort_idle;
      @(negedge clk);
      start = 1;
      abort = 1;
      @(negedge clk);
      start = 0;
      abort = 0;
      for (int n = 0; n < 3; n++) begin
         tests++;
         if ({busy, aborted, ser_clk} !== 3'b000) begin
            fails++;
            $display("FAIL start_abort_idle cycle %0d: {busy,aborted,ser_clk}=%b exp 000", n, {busy, aborted, ser_clk});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset;
      int waited;
      waited = 0;
      @(negedge clk);
      div = 4'd1;
      start = 1;
      @(negedge clk);
      start = 0;
      while (ser_clk !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      tests++;
      if (ser_clk !== 1'b1) begin
         fails++;
         $display("FAIL async_setup: ser_clk=%b exp 1", ser_clk);
      end
      #1 nreset = 0;
      #1;
      tests++;
      if ({busy, done, aborted, ser_clk, ser_data, ser_load, cfg_idx} !== 7'b0) begin
         fails++;
         $display("FAIL async_reset: got %b exp 0", {busy, done, aborted, ser_clk, ser_data, ser_load, cfg_idx});
      end
      @(negedge clk);
      nreset = 1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         tests++;
         if ({busy, ser_clk, ser_load} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_async cycle %0d: got %b exp 000", n, {busy, ser_clk, ser_load});
         end
      end
   endtask

   task automatic test_edge(input int d);
      int exp_done, edges, hi_run;
      logic pclk;
      exp_done = 1 + 2 * (d + 1) + (d + 1) + 1;
      edges = 0; hi_run = 0; pclk = 0;
      @(negedge clk);
      e_div = 2'(d);
      e_start = 1;
      for (int n = 1; n <= exp_done + 2; n++) begin
         @(negedge clk);
         e_start = 0;
         tests++;
         if ({e_done, e_busy} !== {n == exp_done, n < exp_done}) begin
            fails++;
            $display("FAIL edge_timing d=%0d cycle %0d: {done,busy}=%b exp %b", d, n, {e_done, e_busy}, {n == exp_done, n < exp_done});
         end
         if (e_clk && !pclk) begin
            edges++;
            tests++;
            if (e_sdata !== 1'b1) begin
               fails++;
               $display("FAIL edge_data: got %b exp 1", e_sdata);
            end
         end
         if (e_clk) hi_run++;
         else if (pclk) begin
            tests++;
            if (hi_run != d + 1) begin
               fails++;
               $display("FAIL edge_phase d=%0d: got %0d exp %0d", d, hi_run, d + 1);
            end
            hi_run = 0;
         end
         pclk = e_clk;
      end
      tests++;
      if (edges != 1) begin
         fails++;
         $display("FAIL edge_pulses d=%0d: got %0d exp 1", d, edges);
      end
   endtask

   initial begin
      words[0] = 3'b011;
      words[1] = 3'b101;
      test_reset();
      run_main(0, 0, 0);
      run_main(2, 0, 0);
      run_main(15, 0, 0);
      run_main(0, 4, 0);
      run_main(0, 0, 0);
      run_main(1, 0, 1);
      test_start_abort_idle();
      test_async_reset();
      run_main(0, 0, 0);
      test_edge(0);
      test_edge(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
